// File: rtl/lcd_pkg.sv
// Shared types, command bytes and init-sequence helpers for the HD44780-style
// character LCD driver.
package lcd_pkg;

  localparam int CNT_W = 24;  // microsecond count width
  localparam int PRE_W = 16;  // cycles-per-microsecond prescaler width

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP  = 8'h0E;
  localparam logic [7:0] CMD_FUNC8 = 8'h38;
  localparam logic [7:0] CMD_FUNC4 = 8'h28;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0] ROW_ADDR [2] = '{8'h00, 8'h40};

  localparam logic [CNT_W-1:0] WAIT_XFER_US  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_SHORT_US = CNT_W'(50);
  localparam logic [CNT_W-1:0] WAIT_LONG_US  = CNT_W'(2000);
  localparam logic [CNT_W-1:0] WAIT_NIB_US   = CNT_W'(5000);

  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_WRAP
  } lcd_state_e;

  // Who started the transfer currently on the bus; decides where EXEC returns.
  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_REQ,
    SRC_WRAP
  } xfer_src_e;

  typedef struct packed {
    logic [7:0]       data;
    logic             single;   // send only the high nibble (4-bit wake-up)
    logic [CNT_W-1:0] wait_us;
  } init_item_t;

  function automatic logic is_clear_home(input logic [7:0] b);
    return (b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]);
  endfunction

  function automatic logic [CNT_W-1:0] exec_us(input logic rs, input logic [7:0] b);
    return (!rs && is_clear_home(b)) ? WAIT_LONG_US : WAIT_SHORT_US;
  endfunction

  function automatic logic [3:0] init_len(input logic bus4);
    return bus4 ? 4'd8 : 4'd4;
  endfunction

  function automatic init_item_t init_item(input logic bus4, input logic [3:0] idx);
    init_item_t it;
    logic [3:0] k;
    logic [7:0] b;
    k = (bus4 && idx >= 4'd4) ? idx - 4'd4 : idx;
    case (k)
      4'd0:    b = bus4 ? CMD_FUNC4 : CMD_FUNC8;
      4'd1:    b = CMD_DISP;
      4'd2:    b = CMD_CLEAR;
      default: b = CMD_ENTRY;
    endcase
    if (bus4 && idx < 4'd4) begin
      it.data    = (idx == 4'd3) ? 8'h20 : 8'h30;
      it.single  = 1'b1;
      it.wait_us = WAIT_NIB_US;
    end else begin
      it.data    = b;
      it.single  = 1'b0;
      it.wait_us = exec_us(1'b0, b);
    end
    return it;
  endfunction

endpackage

// File: rtl/lcd_char_driver_us_timer.sv
// Loadable microsecond down-counter: load N, done rises after N*US clk cycles.
module lcd_us_timer
  import lcd_pkg::*;
#(
  parameter int US = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] count_us,
  output logic             done
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(US - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (load) begin
      cnt_d = count_us;
      pre_d = PRE_MAX;
    end else if (cnt_q != '0) begin
      if (pre_q == '0) begin
        cnt_d = cnt_q - CNT_W'(1);
        pre_d = PRE_MAX;
      end else begin
        pre_d = pre_q - PRE_W'(1);
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

  // Asserted during the final cycle so the consumer leaves on exactly N*US.
  assign done = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && (pre_q == '0));

endmodule

// File: rtl/lcd_char_driver.sv
// Character LCD write driver: power-on wait, init sequence, request handshake,
// enable-strobe sequencing and automatic line wrap via a cursor tracker.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BUS4     = 0,
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int POWER_US = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int   US = CLK_HZ / 1_000_000;
  localparam logic B4 = (BUS4 != 0);

  lcd_state_e       state_q, state_d;
  xfer_src_e        src_q, src_d;
  logic [3:0]       init_idx_q, init_idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             single_q, single_d;
  logic             nib_q, nib_d;
  logic             gap_q, gap_d;
  logic             armed_q, armed_d;
  logic             init_done_q, init_done_d;
  logic             row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic             tmr_load, tmr_done, start;
  logic [CNT_W-1:0] tmr_count;
  logic [6:0]       col_inc;
  init_item_t       init_cur;

  lcd_us_timer #(.US(US)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .count_us (tmr_count),
    .done     (tmr_done)
  );

  assign init_cur = init_item(B4, init_idx_q);
  assign col_inc  = {1'b0, col_q} + 7'd1;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    init_idx_d  = init_idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    single_d    = single_q;
    nib_d       = nib_q;
    gap_d       = gap_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;
    row_d       = row_q;
    col_d       = col_q;
    wait_d      = wait_q;
    tmr_load    = 1'b0;
    tmr_count   = WAIT_XFER_US;
    start       = 1'b0;

    case (state_q)
      ST_POWER_WAIT: begin
        // The timer is cleared by reset, so arm it on the first cycle.
        if (!armed_q) begin
          armed_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_count = CNT_W'(POWER_US);
        end else if (tmr_done) begin
          state_d    = ST_INIT;
          init_idx_d = '0;
        end
      end

      ST_INIT: begin
        if (init_idx_q == init_len(B4)) begin
          init_done_d = 1'b1;
          row_d       = 1'b0;
          col_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          byte_d     = init_cur.data;
          rs_d       = 1'b0;
          single_d   = init_cur.single;
          wait_d     = init_cur.wait_us;
          src_d      = SRC_INIT;
          init_idx_d = init_idx_q + 4'd1;
          start      = 1'b1;
        end
      end

      ST_IDLE: begin
        if (in_valid && in_ready) begin
          byte_d   = in_data;
          rs_d     = in_rs;
          single_d = 1'b0;
          wait_d   = exec_us(in_rs, in_data);
          src_d    = SRC_REQ;
          start    = 1'b1;
          if (!in_rs) begin
            if (is_clear_home(in_data)) begin
              row_d = 1'b0;
              col_d = '0;
            end else if (in_data[7]) begin
              row_d = in_data[6];
              col_d = in_data[5:0];
            end
          end
        end
      end

      ST_SETUP: if (tmr_done) begin
        state_d  = ST_PULSE;
        tmr_load = 1'b1;
      end

      ST_PULSE: if (tmr_done) begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
      end

      ST_HOLD: if (tmr_done) begin
        state_d  = ST_EXEC;
        tmr_load = 1'b1;
        if (B4 && !single_q && !nib_q) begin
          nib_d = 1'b1;
          gap_d = 1'b1;
        end else begin
          tmr_count = wait_q;
        end
      end

      ST_EXEC: if (tmr_done) begin
        if (gap_q) begin
          gap_d    = 1'b0;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
        end else begin
          case (src_q)
            SRC_INIT: state_d = ST_INIT;
            SRC_REQ: begin
              state_d = ST_IDLE;
              if (rs_q) begin
                if (col_inc == 7'(COLS)) begin
                  col_d   = '0;
                  row_d   = (ROWS > 1) ? ~row_q : 1'b0;
                  state_d = ST_WRAP;
                end else begin
                  col_d = col_inc[5:0];
                end
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_WRAP: begin
        byte_d   = CMD_DDRAM | ROW_ADDR[row_q];
        rs_d     = 1'b0;
        single_d = 1'b0;
        wait_d   = WAIT_SHORT_US;
        src_d    = SRC_WRAP;
        start    = 1'b1;
      end

      default: state_d = ST_POWER_WAIT;
    endcase

    if (start) begin
      state_d   = ST_SETUP;
      nib_d     = 1'b0;
      gap_d     = 1'b0;
      tmr_load  = 1'b1;
      tmr_count = WAIT_XFER_US;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_POWER_WAIT;
      src_q       <= SRC_INIT;
      init_idx_q  <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      single_q    <= 1'b0;
      nib_q       <= 1'b0;
      gap_q       <= 1'b0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      init_idx_q  <= init_idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      single_q    <= single_d;
      nib_q       <= nib_d;
      gap_q       <= gap_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wait_q      <= wait_d;
    end
  end

  // Bus outputs decode straight from registered state, so reset clears them on the edge.
  assign in_ready  = (state_q == ST_IDLE) && init_done_q;
  assign init_done = init_done_q;
  assign lcd_en    = (state_q == ST_PULSE);
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = B4 ? {(nib_q ? byte_q[3:0] : byte_q[7:4]), 4'b0000} : byte_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: 8-bit instance against a transfer-queue model,
// 4-bit instance against its literal init nibble list.
module tb_lcd_char_driver;

  localparam int CLK_HZ   = 1_000_000;
  localparam int US       = CLK_HZ / 1_000_000;
  localparam int COLS     = 16;
  localparam int ROWS     = 2;
  localparam int POWER_US = 100;
  localparam int NIB4 [12] = '{3, 3, 3, 2, 2, 8, 0, 14, 0, 1, 0, 6};
  localparam int GAP4 [12] = '{5000, 5000, 5000, 5000, 0, 50, 0, 50, 0, 2000, 0, 50};

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_us;
  } xfer_t;

  logic clk;
  logic rst8, in_valid8, in_ready8, in_rs8, init_done8;
  logic lcd_en8, lcd_rs8, lcd_rw8;
  logic [7:0] in_data8, lcd_data8;
  logic rst4, in_valid4, in_ready4, in_rs4, init_done4;
  logic lcd_en4, lcd_rs4, lcd_rw4;
  logic [7:0] in_data4, lcd_data4;

  int vectors = 0;
  int miscompares = 0;

  xfer_t      exp_q[$];
  logic [8:0] obs8[$];
  int m_row, m_col;
  int since8, prev_wait8, hi8;
  logic en8_prev;
  int since4 = 0;
  int k4 = 0;
  logic en4_prev = 1'b0;

  lcd_char_driver #(.CLK_HZ(CLK_HZ), .BUS4(0), .COLS(COLS), .ROWS(ROWS), .POWER_US(POWER_US)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_rs(in_rs8),
    .in_data(in_data8), .init_done(init_done8), .lcd_en(lcd_en8), .lcd_rs(lcd_rs8),
    .lcd_rw(lcd_rw8), .lcd_data(lcd_data8));

  lcd_char_driver #(.CLK_HZ(CLK_HZ), .BUS4(1), .COLS(COLS), .ROWS(ROWS), .POWER_US(POWER_US)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .in_rs(in_rs4),
    .in_data(in_data4), .init_done(init_done4), .lcd_en(lcd_en4), .lcd_rs(lcd_rs4),
    .lcd_rw(lcd_rw4), .lcd_data(lcd_data4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int cmd_wait(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? 2000 : 50;
  endfunction

  task automatic push_xfer(input logic rs, input logic [7:0] d, input int w);
    xfer_t x;
    x.rs = rs; x.data = d; x.wait_us = w;
    exp_q.push_back(x);
  endtask

  task automatic model_reset();
    exp_q.delete();
    push_xfer(1'b0, 8'h38, 50);
    push_xfer(1'b0, 8'h0E, 50);
    push_xfer(1'b0, 8'h01, 2000);
    push_xfer(1'b0, 8'h06, 50);
    m_row = 0;
    m_col = 0;
  endtask

  // Cursor model: what the display cursor must be after each accepted request.
  task automatic model_request(input logic rs, input logic [7:0] d);
    push_xfer(rs, d, cmd_wait(rs, d));
    if (!rs) begin
      if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
        m_row = 0; m_col = 0;
      end else if (d[7]) begin
        m_row = int'(d[6]); m_col = int'(d[5:0]);
      end
    end else begin
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_xfer(1'b0, (m_row == 1) ? 8'hC0 : 8'h80, 50);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst8) begin
      since8 = 0; prev_wait8 = POWER_US; en8_prev = 1'b0; hi8 = 0;
    end else begin
      since8++;
      check("rw8", {31'd0, lcd_rw8}, 32'd0);
      check_true("ready_while_busy", !(in_ready8 && exp_q.size() != 0), exp_q.size(), 0);
      if (lcd_en8 && !en8_prev) begin
        obs8.push_back({lcd_rs8, lcd_data8});
        check_true("xfer_expected", exp_q.size() != 0, {lcd_rs8, lcd_data8}, 0);
        if (exp_q.size() != 0) begin
          xfer_t x;
          x = exp_q.pop_front();
          check("xfer8", {23'd0, lcd_rs8, lcd_data8}, {23'd0, x.rs, x.data});
          check_true("gap8", since8 >= prev_wait8 * US, since8, prev_wait8 * US);
          prev_wait8 = x.wait_us;
        end
        since8 = 0;
      end
      if (lcd_en8) hi8++;
      else if (en8_prev) begin
        check_true("pulse_width8", hi8 >= US && hi8 <= US + 1, hi8, US);
        hi8 = 0;
      end
      en8_prev = lcd_en8;
    end
  end

  always @(negedge clk) begin
    if (!rst4) begin
      since4++;
      check("low_nibble4", {28'd0, lcd_data4[3:0]}, 32'd0);
      if (lcd_en4 && !en4_prev) begin
        check_true("xfer4_expected", k4 < 12, k4, 12);
        if (k4 < 12) begin
          check("nib4", {28'd0, lcd_data4[7:4]}, NIB4[k4]);
          check("rs4", {31'd0, lcd_rs4}, 32'd0);
          if (k4 == 0)
            check_true("gap4", since4 >= POWER_US * US, since4, POWER_US * US);
          else if (GAP4[k4-1] != 0)
            check_true("gap4", since4 >= GAP4[k4-1] * US, since4, GAP4[k4-1] * US);
        end
        k4++;
        since4 = 0;
      end
      en4_prev = lcd_en4;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready8 && n < 20000) begin @(negedge clk); n++; end
    check_true(name, in_ready8 === 1'b1, n, 20000);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    @(negedge clk);
    in_valid8 = 1'b1; in_rs8 = rs; in_data8 = d;
    wait_ready("accept_timeout");
    @(negedge clk);
    in_valid8 = 1'b0;
    model_request(rs, d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 30000) begin @(negedge clk); n++; end
    check_true({name, "_drain"}, exp_q.size() == 0, exp_q.size(), 0);
    repeat (prev_wait8 * US + 10) @(negedge clk);
    check({name, "_ready"}, {31'd0, in_ready8}, 32'd1);
    check({name, "_done"}, {31'd0, init_done8}, 32'd1);
  endtask

  initial begin
    int base, cnt, n;
    rst8 = 1'b1; rst4 = 1'b1;
    in_valid8 = 1'b0; in_rs8 = 1'b0; in_data8 = 8'h00;
    in_valid4 = 1'b0; in_rs4 = 1'b0; in_data4 = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_en", {31'd0, lcd_en8}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs8}, 32'd0);
    check("rst_data", {24'd0, lcd_data8}, 32'd0);
    check("rst_ready", {31'd0, in_ready8}, 32'd0);
    check("rst_done", {31'd0, init_done8}, 32'd0);
    model_reset();
    rst8 = 1'b0; rst4 = 1'b0;

    wait_idle("init8");
    check("init_b0", {23'd0, obs8[0]}, 32'h038);
    check("init_b1", {23'd0, obs8[1]}, 32'h00E);
    check("init_b2", {23'd0, obs8[2]}, 32'h001);
    check("init_b3", {23'd0, obs8[3]}, 32'h006);

    // Character held valid across the whole transfer must be taken only once.
    @(negedge clk);
    in_valid8 = 1'b1; in_rs8 = 1'b1; in_data8 = 8'h41;
    wait_ready("hs_accept");
    @(negedge clk);
    model_request(1'b1, 8'h41);
    check("hs_ready_drop", {31'd0, in_ready8}, 32'd0);
    n = 0;
    while (!in_ready8 && n < 5000) begin @(negedge clk); n++; end
    in_valid8 = 1'b0;
    check_true("hs_ready_gap", n >= 50 * US && n < 5000, n, 50 * US);
    wait_idle("hs");
    cnt = 0;
    foreach (obs8[i]) if (obs8[i] == 9'h141) cnt++;
    check("hs_once", cnt, 32'd1);

    send(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) send(1'b1, 8'h41 + 8'(i));
    wait_idle("wrap1");
    check("wrap_to_row1", {23'd0, obs8[obs8.size()-1]}, 32'h0C0);
    for (int i = 0; i < 16; i++) send(1'b1, 8'h61 + 8'(i));
    wait_idle("wrap2");
    check("wrap_to_row0", {23'd0, obs8[obs8.size()-1]}, 32'h080);

    // 0xC5 puts the cursor at row 1 col 5; eleven characters reach column 16.
    send(1'b0, 8'hC5);
    for (int i = 0; i < 11; i++) send(1'b1, 8'h30 + 8'(i));
    wait_idle("ddram");
    check("ddram_wrap", {23'd0, obs8[obs8.size()-1]}, 32'h080);
    send(1'b1, 8'h5A);
    send(1'b0, 8'h01);
    wait_idle("clear");
    for (int i = 0; i < 16; i++) send(1'b1, 8'h21 + 8'(i));
    wait_idle("clear_wrap");
    check("clear_origin", {23'd0, obs8[obs8.size()-1]}, 32'h0C0);

    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] d;
      logic rs;
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        rs = 1'b1; d = 8'($urandom_range(32'h20, 32'h7E));
      end else if (r < 75) begin
        rs = 1'b0; d = {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, COLS - 1))};
      end else if (r < 90) begin
        rs = 1'b0; d = 8'($urandom_range(4, 127));
      end else begin
        rs = 1'b0; d = 8'($urandom_range(1, 3));
      end
      send(rs, d);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle("random");

    // Reset landing while the enable strobe is high.
    @(negedge clk);
    in_valid8 = 1'b1; in_rs8 = 1'b0; in_data8 = 8'h0C;
    wait_ready("mid_accept");
    @(negedge clk);
    in_valid8 = 1'b0;
    model_request(1'b0, 8'h0C);
    n = 0;
    while (!lcd_en8 && n < 100) begin @(negedge clk); n++; end
    check("mid_en_seen", {31'd0, lcd_en8}, 32'd1);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_en_drop", {31'd0, lcd_en8}, 32'd0);
    check("mid_done_drop", {31'd0, init_done8}, 32'd0);
    check("mid_ready_drop", {31'd0, in_ready8}, 32'd0);
    check("mid_data_clear", {24'd0, lcd_data8}, 32'd0);
    repeat (3) @(negedge clk);
    model_reset();
    base = obs8.size();
    rst8 = 1'b0;
    wait_idle("reinit");
    check("reinit_b0", {23'd0, obs8[base]}, 32'h038);
    check("reinit_b2", {23'd0, obs8[base+2]}, 32'h001);
    check("reinit_b3", {23'd0, obs8[base+3]}, 32'h006);

    n = 0;
    while (!init_done4 && n < 40000) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    check("init4_count", k4, 32'd12);
    check("init4_done", {31'd0, init_done4}, 32'd1);
    check("init4_ready", {31'd0, in_ready4}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 The parameter CLK_HZ SHALL default to 50_000_000 and set the clk frequency in Hz; US = CLK_HZ/1_000_000 cycles per microsecond.
REQ-002 The parameter BUS4 SHALL default to 0; 0 selects an 8-bit LCD bus and 1 selects a 4-bit LCD bus on lcd_data[7:4].
REQ-003 The parameter COLS SHALL default to 16 and give the visible columns per row (1..40).
REQ-004 The parameter ROWS SHALL default to 2 and give the display rows (1 or 2).
REQ-005 The parameter POWER_US SHALL default to 40000 and give the power-on wait in us.
REQ-006 The port clk SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-007 The port rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-008 The port in_valid SHALL be an input, 1 bit wide: a request is present.
REQ-009 The port in_ready SHALL be an output, 1 bit wide: the driver accepts a request this cycle.
REQ-010 The port in_rs SHALL be an input, 1 bit wide: 0 = command, 1 = character.
REQ-011 The port in_data SHALL be an input, 8 bits wide: the command or character byte.
REQ-012 The port init_done SHALL be an output, 1 bit wide: the init sequence is complete.
REQ-013 The port lcd_en SHALL be an output, 1 bit wide: the LCD enable strobe.
REQ-014 The port lcd_rs SHALL be an output, 1 bit wide: the LCD register select.
REQ-015 The port lcd_rw SHALL be an output, 1 bit wide, constant 0 (write only).
REQ-016 The port lcd_data SHALL be an output, 8 bits wide: the LCD bus; when BUS4=1, lcd_data[3:0] is 0.

Function
REQ-017 Every LCD transfer SHALL be sequenced SETUP for 1 us (rs/data stable, en=0), then PULSE for 1 us (en=1), then HOLD for 1 us (en=0, data held), then EXEC wait.
REQ-018 The EXEC wait SHALL be 2000 us for clear (0x01) and home (0x02/0x03) and 50 us for all other bytes.
REQ-019 When BUS4=1, each byte SHALL be sent as two transfers, high nibble first; the EXEC wait follows the second nibble only, with 1 us between nibbles.
REQ-020 The state set SHALL be POWER_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC, WRAP.
REQ-021 After reset, the driver SHALL wait POWER_US us in POWER_WAIT, then enter INIT.
REQ-022 In 8-bit mode, INIT SHALL send the bytes 0x38, 0x0E, 0x01, 0x06.
REQ-023 In 4-bit mode, INIT SHALL send the single nibbles 0x3, 0x3, 0x3, 0x2, each followed by a 5000 us wait, then the bytes 0x28, 0x0E, 0x01, 0x06.
REQ-024 When INIT completes, init_done SHALL be set to 1 and stay 1 until reset, the cursor tracker SHALL be set to row 0, column 0, and the state SHALL go to IDLE.
REQ-025 in_ready SHALL be 1 only in IDLE with init_done=1.
REQ-026 A request SHALL be accepted when in_valid&in_ready; in_rs/in_data are registered and in_ready drops the next cycle.
REQ-027 in_valid without in_ready SHALL be ignored; the requester holds the request.
REQ-028 A clear or home command SHALL set the tracker to row 0, column 0.
REQ-029 A command with in_data[7]=1 (set DDRAM) SHALL set the tracker to row=in_data[6] and column=in_data[5:0].
REQ-030 Any other command SHALL leave the tracker unchanged.
REQ-031 After a character's EXEC wait, the column SHALL increment by 1.
REQ-032 If the incremented column equals COLS, the column SHALL become 0, the row SHALL become (row+1) mod ROWS, and the driver SHALL enter WRAP.
REQ-033 In WRAP, the driver SHALL issue 0x80|ROW_ADDR[row] (row 0 = 0x00, row 1 = 0x40) through the full transfer sequence before returning to IDLE.
REQ-034 Exactly one timer SHALL serve all waits; a wait of N us SHALL last N*US cycles, ±1 cycle.

Reset
REQ-035 While rst=1 at a clk edge, the outputs SHALL become lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0, in_ready=0, init_done=0; the state SHALL become POWER_WAIT, and the timer and tracker SHALL clear.
REQ-036 A reset during any state, including mid-PULSE, SHALL drop lcd_en on the same edge and restart the full power-on and init sequence.

Structure
REQ-037 The package lcd_pkg SHALL hold the state enum, the command constants (CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_ENTRY=0x06, CMD_DISP=0x0E, CMD_FUNC8=0x38, CMD_FUNC4=0x28, CMD_DDRAM=0x80), and the ROW_ADDR table.
REQ-038 The sub-module lcd_us_timer SHALL be a loadable down-counter with a us prescaler (load, count_us, done) that the FSM instantiates once.

Verification
REQ-039 (8-bit init) With CLK_HZ=1_000_000 and POWER_US=100, release rst -> four EN pulses with data 0x38, 0x0E, 0x01, 0x06 and rs=0; a gap of ≥2000 cycles after 0x01; then init_done=1 and in_ready=1.
REQ-040 (4-bit init) With BUS4=1 -> nibbles 3, 3, 3, 2 on lcd_data[7:4], then byte pairs 2/8, 0/E, 0/1, 0/6, and lcd_data[3:0]=0 throughout.
REQ-041 (Handshake) Character 0x41 held with in_valid=1 -> accepted exactly once; rs=1, data=0x41 on one EN pulse; in_ready returns after ≥50 us.
REQ-042 (Wrap) Writing 16 characters from column 0 on row 0 -> an automatic 0x C0 command after the 16th; 16 more characters -> an automatic 0x80 command.
REQ-043 (Tracker commands) Command 0xC5 then one character, and command 0x01 -> tracker reads row 1, column 6, then row 0, column 0 after the clear, with a wait of ≥2000 us.
REQ-044 (Reset mid-pulse) Assert rst while lcd_en=1 -> lcd_en=0 and init_done=0 on the next edge, and a complete init sequence is repeated after release.
